// File: rtl/sram_bridge.sv
// sram_bridge: bridges the Mips 32-bit word request port to a 16-bit
// asynchronous SRAM. An accepted request runs as up to two half-word phases.
// The low half comes first, then the high half. Each phase is one setup cycle
// followed by WAIT_CYCLES strobe cycles. The two read halves are assembled
// into rsp_rdata, and rsp_valid pulses for one cycle when the request is done.
//
// Ports
//   clock, reset          rising-edge clock; asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = write, 0 = read
//   req_addr              byte address; bits [ADDR_W:2] select the word
//   req_wdata, req_be     write data and byte enables (writes only)
//   rsp_valid, rsp_rdata  completion pulse and registered read data
//   addr, data            SRAM half-word address and bidirectional data bus
//   wre, oute             SRAM write / output enables (active-low)
//   hb_mask, lb_mask      SRAM upper / lower byte enables (active-low)
//   chip_en               SRAM chip enable (active-low)
module sram_bridge #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [3:0]          req_be,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0]   addr,
  inout  wire  [DATA_W-1:0]   data,
  output logic                wre,
  output logic                oute,
  output logic                hb_mask,
  output logic                lb_mask,
  output logic                chip_en
);
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                we_q;
  logic [ADDR_W-2:0]   waddr_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic [3:0]          be_q;
  logic                drive;
  logic [DATA_W-1:0]   dout;

  logic                src_we;
  logic [ADDR_W-2:0]   src_waddr;
  logic [2*DATA_W-1:0] src_wdata;
  logic [3:0]          src_be;
  logic                ph_half;
  logic [ADDR_W-1:0]   ph_addr;
  logic                ph_lb;
  logic                ph_hb;
  logic [DATA_W-1:0]   ph_dout;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:ADDR_W+1], req_addr[1:0]};

  assign data = drive ? dout : {DATA_W{1'bz}};

  // Setup values for the next phase. From IDLE they come straight from the
  // request being accepted; from LO they come from the latched request and
  // always target the high half.
  always_comb begin
    if (state == IDLE) begin
      src_we    = req_we;
      src_waddr = req_addr[ADDR_W:2];
      src_wdata = req_wdata;
      src_be    = req_be;
      ph_half   = req_we && (req_be[1:0] == 2'b00);
    end else begin
      src_we    = we_q;
      src_waddr = waddr_q;
      src_wdata = wdata_q;
      src_be    = be_q;
      ph_half   = 1'b1;
    end
    ph_addr = {src_waddr, ph_half};
    ph_lb   = src_we & ~src_be[{ph_half, 1'b0}];
    ph_hb   = src_we & ~src_be[{ph_half, 1'b1}];
    ph_dout = ph_half ? src_wdata[2*DATA_W-1:DATA_W] : src_wdata[DATA_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      addr      <= '0;
      drive     <= 1'b0;
      dout      <= '0;
      wre       <= 1'b1;
      oute      <= 1'b1;
      hb_mask   <= 1'b1;
      lb_mask   <= 1'b1;
      chip_en   <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            waddr_q   <= req_addr[ADDR_W:2];
            wdata_q   <= req_wdata;
            be_q      <= req_be;
            req_ready <= 1'b0;
            if (req_we && (req_be == 4'b0000)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state   <= ph_half ? HI : LO;
              cnt     <= '0;
              chip_en <= 1'b0;
              wre     <= 1'b1;
              oute    <= 1'b1;
              addr    <= ph_addr;
              lb_mask <= ph_lb;
              hb_mask <= ph_hb;
              drive   <= src_we;
              dout    <= ph_dout;
            end
          end
        end
        LO, HI: begin
          if (cnt != LAST) begin
            cnt  <= cnt + 1'b1;
            wre  <= ~we_q;
            oute <= we_q;
          end else begin
            // Last strobe cycle: the SRAM read data is stable now.
            if (!we_q) begin
              if (state == LO) rsp_rdata[DATA_W-1:0] <= data;
              else             rsp_rdata[2*DATA_W-1:DATA_W] <= data;
            end
            if ((state == LO) && (!we_q || (be_q[3:2] != 2'b00))) begin
              state   <= HI;
              cnt     <= '0;
              wre     <= 1'b1;
              oute    <= 1'b1;
              addr    <= ph_addr;
              lb_mask <= ph_lb;
              hb_mask <= ph_hb;
              drive   <= src_we;
              dout    <= ph_dout;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              chip_en   <= 1'b1;
              wre       <= 1'b1;
              oute      <= 1'b1;
              lb_mask   <= 1'b1;
              hb_mask   <= 1'b1;
              drive     <= 1'b0;
            end
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_bridge.sv
module tb_sram_bridge;
  localparam int NTR = 8;
  // Undriven bus reads as all ones through the pull-ups.
  localparam logic [15:0] FLOAT = 16'hFFFF;
  localparam logic [15:0] ROMK  = 16'hA5C3;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b0;

  int checks = 0;
  int errors = 0;

  logic        req_valid, req_we, req_ready, rsp_valid;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic [17:0] addr;
  wire  [15:0] data;
  logic        wre, oute, hb_mask, lb_mask, chip_en;

  logic        req_valid3, req_we3, req_ready3, rsp_valid3;
  logic [31:0] req_addr3, req_wdata3, rsp_rdata3;
  logic [3:0]  req_be3;
  logic [17:0] addr3;
  wire  [15:0] data3;
  logic        wre3, oute3, hb_mask3, lb_mask3, chip_en3;

  sram_bridge #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .addr(addr), .data(data),
    .wre(wre), .oute(oute), .hb_mask(hb_mask), .lb_mask(lb_mask), .chip_en(chip_en));

  sram_bridge #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we3), .req_addr(req_addr3), .req_wdata(req_wdata3), .req_be(req_be3),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .addr(addr3), .data(data3),
    .wre(wre3), .oute(oute3), .hb_mask(hb_mask3), .lb_mask(lb_mask3), .chip_en(chip_en3));

  // SRAM device for dut: small array, cleared while reset is low.
  logic [15:0] sram [256];
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (data[i]);
  end
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) sram[i] <= '0;
    end else if (!chip_en && !wre) begin
      if (!lb_mask) sram[addr[7:0]][7:0]  <= data[7:0];
      if (!hb_mask) sram[addr[7:0]][15:8] <= data[15:8];
    end
  end
  assign data = (!chip_en && !oute) ? sram[addr[7:0]] : 16'bz;

  // Read-only pattern device for dut3.
  assign data3 = (!chip_en3 && !oute3) ? (addr3[15:0] ^ ROMK) : 16'bz;

  // Word-level reference memory and last read response.
  logic [31:0] ref_mem [16];
  logic [31:0] last_rdata;

  // Per-cycle trace after acceptance: index k is cycle T+k.
  logic        t_ce [NTR+1], t_wre [NTR+1], t_oute [NTR+1], t_hb [NTR+1], t_lb [NTR+1];
  logic        t_rv [NTR+1], t_rdy [NTR+1];
  logic [17:0] t_addr [NTR+1];
  logic [15:0] t_data [NTR+1];
  logic [31:0] t_rdata [NTR+1];

  task automatic run_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic ok);
    int unsigned n;
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    ok = req_ready;
    @(negedge clock);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom);
    for (int k = 1; k <= NTR; k++) begin
      t_ce[k] = chip_en; t_wre[k] = wre; t_oute[k] = oute; t_hb[k] = hb_mask;
      t_lb[k] = lb_mask; t_rv[k] = rsp_valid; t_rdy[k] = req_ready;
      t_addr[k] = addr; t_data[k] = data; t_rdata[k] = rsp_rdata;
      if (k < NTR) @(negedge clock);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    last_rdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({wre, oute, chip_en, hb_mask, lb_mask, rsp_valid, req_ready} !== 7'b1111101) begin
      errors++;
      $display("FAIL reset_ctl got %b want %b",
               {wre, oute, chip_en, hb_mask, lb_mask, rsp_valid, req_ready}, 7'b1111101);
    end
    checks++;
    if ({addr, rsp_rdata} !== 50'd0) begin
      errors++;
      $display("FAIL reset_regs got addr %h rdata %h want 0", addr, rsp_rdata);
    end
    checks++;
    if (data !== FLOAT) begin
      errors++;
      $display("FAIL reset_data got %h want %h", data, FLOAT);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({req_ready, rsp_valid, chip_en} !== 3'b101) begin
      errors++;
      $display("FAIL reset_idle got %b want %b", {req_ready, rsp_valid, chip_en}, 3'b101);
    end
  endtask

  task automatic test_reset_midrun();
    logic seen_rv;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0020;
    req_wdata = $urandom; req_be = 4'hF;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (wre !== 1'b0) begin
      errors++;
      $display("FAIL midrun_strobe got wre %b want 0", wre);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({wre, oute, chip_en, hb_mask, lb_mask, rsp_valid, req_ready} !== 7'b1111101) begin
      errors++;
      $display("FAIL midrun_ctl got %b want %b",
               {wre, oute, chip_en, hb_mask, lb_mask, rsp_valid, req_ready}, 7'b1111101);
    end
    checks++;
    if (data !== FLOAT) begin
      errors++;
      $display("FAIL midrun_data got %h want %h", data, FLOAT);
    end
    repeat (2) @(negedge clock);
    clear_model();
    reset = 1'b1;
    seen_rv = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (rsp_valid) seen_rv = 1'b1;
    end
    checks++;
    if ({seen_rv, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL midrun_norsp got rv_seen,ready %b want 01", {seen_rv, req_ready});
    end
  endtask

  task automatic test_write_full();
    logic ok;
    logic [6:1] wv, rv;
    run_req(1'b1, 32'h0040_0008, 32'hDEAD_BEEF, 4'hF, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_accept got timeout want accept"); end
    for (int k = 1; k <= 6; k++) begin wv[k] = t_wre[k]; rv[k] = t_rv[k]; end
    checks++;
    if ({t_addr[1], t_addr[3]} !== {18'h00004, 18'h00005}) begin
      errors++;
      $display("FAIL wr_addr got %h %h want 00004 00005", t_addr[1], t_addr[3]);
    end
    checks++;
    if ({t_data[1], t_data[2], t_data[3], t_data[4]} !== 64'hBEEF_BEEF_DEAD_DEAD) begin
      errors++;
      $display("FAIL wr_data got %h %h %h %h want BEEF BEEF DEAD DEAD",
               t_data[1], t_data[2], t_data[3], t_data[4]);
    end
    checks++;
    if (wv !== 6'b110101) begin errors++; $display("FAIL wr_wre got %b want 110101", wv); end
    checks++;
    if ({t_rdy[6], rv} !== 7'b1010000) begin
      errors++;
      $display("FAIL wr_rsp got rdy6,rv %b want 1010000", {t_rdy[6], rv});
    end
    checks++;
    if ({t_hb[1], t_lb[1], t_hb[3], t_lb[3]} !== 4'b0000) begin
      errors++;
      $display("FAIL wr_masks got %b want 0000", {t_hb[1], t_lb[1], t_hb[3], t_lb[3]});
    end
    ref_mem[2] = 32'hDEAD_BEEF;
  endtask

  task automatic test_read_back();
    logic ok;
    logic [6:1] ov, wv, rv;
    run_req(1'b0, 32'h0040_0008, $urandom, 4'($urandom), ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_accept got timeout want accept"); end
    for (int k = 1; k <= 6; k++) begin ov[k] = t_oute[k]; wv[k] = t_wre[k]; rv[k] = t_rv[k]; end
    checks++;
    if ({ov, wv} !== {6'b110101, 6'b111111}) begin
      errors++;
      $display("FAIL rd_strobes got oute %b wre %b want 110101 111111", ov, wv);
    end
    checks++;
    if (rv !== 6'b010000) begin errors++; $display("FAIL rd_rv got %b want 010000", rv); end
    checks++;
    if (t_rdata[5] !== ref_mem[2]) begin
      errors++;
      $display("FAIL rd_data got %h want %h", t_rdata[5], ref_mem[2]);
    end
    last_rdata = ref_mem[2];
  endtask

  task automatic test_hi_only();
    logic ok;
    logic [4:1] rv;
    run_req(1'b1, 32'h0000_0010, 32'h00AA_0000, 4'b0100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hi_accept got timeout want accept"); end
    for (int k = 1; k <= 4; k++) rv[k] = t_rv[k];
    checks++;
    if ({t_addr[1], t_hb[1], t_lb[1], t_wre[2]} !== {18'h00009, 3'b100}) begin
      errors++;
      $display("FAIL hi_phase got addr %h hb,lb,wre %b want 00009 100",
               t_addr[1], {t_hb[1], t_lb[1], t_wre[2]});
    end
    checks++;
    if ({t_data[1], t_data[2]} !== 32'h00AA_00AA) begin
      errors++;
      $display("FAIL hi_data got %h %h want 00AA 00AA", t_data[1], t_data[2]);
    end
    checks++;
    if ({t_ce[4], rv} !== 5'b10100) begin
      errors++;
      $display("FAIL hi_rsp got ce4,rv %b want 10100", {t_ce[4], rv});
    end
    checks++;
    if (t_rdata[3] !== last_rdata) begin
      errors++;
      $display("FAIL hi_rdata got %h want %h", t_rdata[3], last_rdata);
    end
    ref_mem[4][23:16] = 8'hAA;
  endtask

  task automatic test_be_zero();
    logic ok;
    logic [4:1] cv, rv;
    run_req(1'b1, 32'h0000_0014, $urandom, 4'b0000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bez_accept got timeout want accept"); end
    for (int k = 1; k <= 4; k++) begin cv[k] = t_ce[k]; rv[k] = t_rv[k]; end
    checks++;
    if ({cv, rv, t_rdy[2]} !== 9'b1111_0001_1) begin
      errors++;
      $display("FAIL bez_seq got ce %b rv %b rdy2 %b want 1111 0001 1", cv, rv, t_rdy[2]);
    end
    checks++;
    if (t_data[1] !== FLOAT) begin
      errors++;
      $display("FAIL bez_data got %h want %h", t_data[1], FLOAT);
    end
  endtask

  task automatic test_random(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      logic we, ok, in_ph, strobe, h;
      logic [31:0] a, wd, exp_rd;
      logic [3:0] be;
      logic [4:0] exp_ctl;
      logic [1:0] exp_msk;
      logic [15:0] exp_d;
      logic hs [4];
      int unsigned widx, nh, k_rsp;
      we = 1'($urandom_range(0, 1));
      widx = $urandom_range(0, 15);
      a = $urandom;
      a[18:2] = 17'(widx);
      wd = $urandom;
      be = 4'($urandom);
      run_req(we, a, wd, be, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rnd_accept got timeout want accept"); end
      nh = 0;
      hs[0] = 1'b0; hs[1] = 1'b0; hs[2] = 1'b0; hs[3] = 1'b0;
      if (!we || (be[1:0] != 2'b00)) begin hs[nh] = 1'b0; nh++; end
      if (!we || (be[3:2] != 2'b00)) begin hs[nh] = 1'b1; nh++; end
      k_rsp = 2 * nh + 1;
      exp_rd = we ? last_rdata : ref_mem[widx];
      for (int unsigned k = 1; k <= NTR; k++) begin
        in_ph  = (k <= 2 * nh);
        strobe = ((k % 2) == 0);
        h      = in_ph ? hs[(k - 1) / 2] : 1'b0;
        exp_ctl = {!in_ph, !(in_ph && strobe && we), !(in_ph && strobe && !we),
                   k == k_rsp, k > k_rsp};
        checks++;
        if ({t_ce[k], t_wre[k], t_oute[k], t_rv[k], t_rdy[k]} !== exp_ctl) begin
          errors++;
          $display("FAIL rnd_ctl k=%0d got %b want %b", k,
                   {t_ce[k], t_wre[k], t_oute[k], t_rv[k], t_rdy[k]}, exp_ctl);
        end
        if (in_ph) begin
          exp_msk = we ? {~be[{h, 1'b1}], ~be[{h, 1'b0}]} : 2'b00;
          checks++;
          if ({t_addr[k], t_hb[k], t_lb[k]} !== {17'(widx), h, exp_msk}) begin
            errors++;
            $display("FAIL rnd_addr k=%0d got %h %b want %h %b", k, t_addr[k],
                     {t_hb[k], t_lb[k]}, {17'(widx), h}, exp_msk);
          end
        end
        if (!(in_ph && strobe && !we)) begin
          exp_d = (in_ph && we) ? (h ? wd[31:16] : wd[15:0]) : FLOAT;
          checks++;
          if (t_data[k] !== exp_d) begin
            errors++;
            $display("FAIL rnd_data k=%0d got %h want %h", k, t_data[k], exp_d);
          end
        end
        if (k == k_rsp) begin
          checks++;
          if (t_rdata[k] !== exp_rd) begin
            errors++;
            $display("FAIL rnd_rdata got %h want %h", t_rdata[k], exp_rd);
          end
        end
      end
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[widx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        last_rdata = ref_mem[widx];
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned s_acc [2], s_rsp [2], n_oe [2], w [2];
    int unsigned n_acc, n_rsp, bad;
    logic [31:0] rd [2], exp_rd;
    for (int i = 0; i < 2; i++) begin
      s_acc[i] = 0; s_rsp[i] = 0; n_oe[i] = 0; rd[i] = '0;
      w[i] = $urandom_range(0, 1023);
    end
    n_acc = 0; n_rsp = 0; bad = 0;
    @(negedge clock);
    req_valid3 = 1'b1; req_we3 = 1'b0; req_addr3 = $urandom; req_addr3[18:2] = 17'(w[0]);
    for (int unsigned s = 0; s < 60 && n_rsp < 2; s++) begin
      if (!oute3 && n_acc > 0) n_oe[n_acc - 1]++;
      if (!wre3 || (!chip_en3 && (hb_mask3 || lb_mask3))) bad++;
      if (rsp_valid3) begin s_rsp[n_rsp] = s; rd[n_rsp] = rsp_rdata3; n_rsp++; end
      if (req_valid3 && req_ready3) begin s_acc[n_acc] = s; n_acc++; end
      @(negedge clock);
      if (n_acc == 1) begin req_addr3 = $urandom; req_addr3[18:2] = 17'(w[1]); end
      if (n_acc == 2) req_valid3 = 1'b0;
    end
    req_valid3 = 1'b0;
    checks++;
    if (n_rsp != 2) begin errors++; $display("FAIL b2b_done got %0d responses want 2", n_rsp); end
    checks++;
    if (s_rsp[0] - s_acc[0] != 9) begin
      errors++;
      $display("FAIL b2b_lat0 got %0d want 9", s_rsp[0] - s_acc[0]);
    end
    checks++;
    if (s_acc[1] - s_rsp[0] != 1) begin
      errors++;
      $display("FAIL b2b_gap got %0d want 1", s_acc[1] - s_rsp[0]);
    end
    checks++;
    if (s_rsp[1] - s_acc[1] != 9) begin
      errors++;
      $display("FAIL b2b_lat1 got %0d want 9", s_rsp[1] - s_acc[1]);
    end
    for (int i = 0; i < 2; i++) begin
      exp_rd = {16'(2 * w[i] + 1) ^ ROMK, 16'(2 * w[i]) ^ ROMK};
      checks++;
      if ({rd[i], n_oe[i]} !== {exp_rd, 32'd6}) begin
        errors++;
        $display("FAIL b2b_read%0d got %h oe_cycles %0d want %h 6", i, rd[i], n_oe[i], exp_rd);
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_pins got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    req_valid3 = 1'b0; req_we3 = 1'b0; req_addr3 = '0; req_wdata3 = $urandom; req_be3 = 4'hF;
    clear_model();
    test_reset();
    test_reset_midrun();
    test_write_full();
    test_read_back();
    test_hi_only();
    test_be_zero();
    test_random(60);
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
